// File: rtl/voice_scheduler.sv
// voice_scheduler: assigns streamed notes to free voice slots, times each
// voice's duration in beats and holds off the stream during rests.
// Optional feature: define VOICE_STEAL_EN to let a note take over the voice
// with the least remaining time when every voice is busy.
module voice_scheduler #(
  parameter int unsigned NUM_VOICES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play_enable,
  input  logic                    beat,
  input  logic                    note_valid,
  input  logic [5:0]              note_in,
  input  logic [5:0]              duration_in,
  output logic                    note_ready,
  output logic [NUM_VOICES-1:0]   voice_load,
  output logic [6*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic                    all_done
);

  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 6;
  localparam int unsigned IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DUR_W-1:0]        rest_cnt_q, rest_cnt_d;
  logic [DUR_W-1:0]        cnt_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]   free_c;
  logic [NUM_VOICES-1:0]   load_c;
  logic [IDX_W-1:0]        target_c;
  logic                    any_free_c;
  logic                    tick_c;
  logic                    accept_c;
  logic                    is_note_c;
  logic                    is_rest_c;

  // Per-voice free flags from registered counts
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      free_c[i] = (cnt_q[i] == '0);
    end
  end

  assign any_free_c   = |free_c;
  assign voice_active = ~free_c;
  assign all_done     = (state_q == IDLE) && (&free_c);
  assign tick_c       = beat && play_enable;

  // Handshake: ready only in IDLE while playing and a note can be placed
  assign note_ready = !reset && play_enable && (state_q == IDLE) &&
                      (any_free_c || (note_in == '0) || (duration_in == '0) || STEAL_EN);
  assign accept_c   = note_valid && note_ready;
  assign is_note_c  = (note_in != '0) && (duration_in != '0);
  assign is_rest_c  = (note_in == '0) && (duration_in != '0);

  // Target voice selection
`ifdef VOICE_STEAL_EN
  // Smallest remaining count, lowest index on ties; a free voice always wins
  always_comb begin
    logic [DUR_W-1:0] min_cnt;
    target_c = '0;
    min_cnt  = cnt_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (cnt_q[i] < min_cnt) begin
        min_cnt  = cnt_q[i];
        target_c = IDX_W'(i);
      end
    end
  end
`else
  // Lowest-index free voice
  always_comb begin
    target_c = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (free_c[i]) begin
        target_c = IDX_W'(i);
      end
    end
  end
`endif

  // One-hot load request for the accepted note
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      load_c[i] = accept_c && is_note_c && (target_c == IDX_W'(i));
    end
  end

  // Voice countdowns: load beats decrement on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (play_enable) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_c[i]) begin
          cnt_q[i] <= duration_in;
        end else if (beat && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - DUR_W'(1);
        end
      end
    end
  end

  // Registered load strobes and held note numbers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      voice_load <= '0;
      voice_note <= '0;
    end else begin
      voice_load <= load_c;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_c[i]) begin
          voice_note[NOTE_W*i +: NOTE_W] <= note_in;
        end
      end
    end
  end

  // FSM state and rest counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rest_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rest_cnt_q <= rest_cnt_d;
    end
  end

  // Next state: enter REST on an accepted rest, leave when it runs out
  always_comb begin
    state_d    = state_q;
    rest_cnt_d = rest_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c && is_rest_c) begin
          state_d    = REST;
          rest_cnt_d = duration_in;
        end
      end
      REST: begin
        if (rest_cnt_q == '0) begin
          state_d = IDLE;
        end else if (tick_c) begin
          rest_cnt_d = rest_cnt_q - DUR_W'(1);
          if (rest_cnt_q == DUR_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        rest_cnt_d = '0;
      end
    endcase
  end

endmodule
